uart_cmd_framer: RTL and testbench

UART_CMD_FRAMER -- requirements
Module: uart_cmd_framer

---
 rtl/uart_cmd_pkg.sv | 74 +++++++
 rtl/uart_cmd_framer_byte_ser.sv | 143 ++++++++++++++
 rtl/uart_cmd_framer.sv | 96 +++++++++
 tb/tb_uart_cmd_framer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared encodings for the UART command framer: command types, opcodes,
// the byte serializer state set and the command-to-byte mapping.
package uart_cmd_pkg;

    localparam logic [1:0] CMD_REG_WR  = 2'b00;
    localparam logic [1:0] CMD_REG_RD  = 2'b01;
    localparam logic [1:0] CMD_ALU_OPS = 2'b10;
    localparam logic [1:0] CMD_ALU_NOP = 2'b11;

    localparam logic [7:0] OP_REG_WR  = 8'hAA;
    localparam logic [7:0] OP_REG_RD  = 8'hBB;
    localparam logic [7:0] OP_ALU_OPS = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } ser_state_e;

    // Command fields captured at acceptance.
    typedef struct packed {
        logic [1:0] typ;
        logic [3:0] addr;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] func;
        logic       par_en;
        logic       par_typ;
        logic [7:0] baud_div;
    } cmd_cfg_t;

    // Index of the final byte of a command (byte count minus one).
    function automatic logic [1:0] cmd_last_idx(input logic [1:0] typ);
        case (typ)
            CMD_REG_WR:  cmd_last_idx = 2'd2;
            CMD_REG_RD:  cmd_last_idx = 2'd1;
            CMD_ALU_OPS: cmd_last_idx = 2'd3;
            default:     cmd_last_idx = 2'd1;
        endcase
    endfunction

    // Byte 'idx' of the frame for the given command.
    function automatic logic [7:0] cmd_byte(input cmd_cfg_t c, input logic [1:0] idx);
        cmd_byte = 8'h00;
        case (c.typ)
            CMD_REG_WR: begin
                case (idx)
                    2'd0:    cmd_byte = OP_REG_WR;
                    2'd1:    cmd_byte = {4'h0, c.addr};
                    default: cmd_byte = c.a;
                endcase
            end
            CMD_REG_RD: begin
                cmd_byte = (idx == 2'd0) ? OP_REG_RD : {4'h0, c.addr};
            end
            CMD_ALU_OPS: begin
                case (idx)
                    2'd0:    cmd_byte = OP_ALU_OPS;
                    2'd1:    cmd_byte = c.a;
                    2'd2:    cmd_byte = c.b;
                    default: cmd_byte = {4'h0, c.func};
                endcase
            end
            default: begin
                cmd_byte = (idx == 2'd0) ? OP_ALU_NOP : {4'h0, c.func};
            end
        endcase
    endfunction

endpackage

// File: rtl/uart_cmd_framer_byte_ser.sv
// Single-byte UART serializer: start, 8 data bits LSB first, optional
// parity, stop and GAP_BITS idle bits. A start request in the final cycle
// of a byte chains straight into the next start bit.
//
//   state     | meaning
//   ----------+-------------------------------------------
//   ST_IDLE   | line high, waiting for start
//   ST_START  | start bit (0) on the line
//   ST_DATA   | data bit bit_cnt on the line
//   ST_PARITY | parity bit on the line
//   ST_STOP   | stop bit (1) on the line
//   ST_GAP    | inter-byte idle bits, gap_cnt remaining after this one
module uart_byte_ser
    import uart_cmd_pkg::*;
#(
    parameter int GAP_BITS = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       par_en,
    input  logic       par_typ,
    input  logic [7:0] baud_div,
    output logic       tx,
    output logic       done
);

    localparam logic [3:0] GAP_LOAD = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

    ser_state_e state, state_nxt;
    logic [7:0] baud_cnt, baud_nxt;
    logic [7:0] shift, shift_nxt;
    logic [2:0] bit_cnt, bit_nxt;
    logic [3:0] gap_cnt, gap_nxt;
    logic       par_bit, par_nxt;
    logic       tx_q, tx_nxt;
    logic       tick;
    logic       load;

    // State register and registered line output.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= ST_IDLE;
            baud_cnt <= 8'd0;
            shift    <= 8'd0;
            bit_cnt  <= 3'd0;
            gap_cnt  <= 4'd0;
            par_bit  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            shift    <= shift_nxt;
            bit_cnt  <= bit_nxt;
            gap_cnt  <= gap_nxt;
            par_bit  <= par_nxt;
            tx_q     <= tx_nxt;
        end
    end

    // Next-state: baud down-counter reaching zero marks the bit boundary.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        shift_nxt = shift;
        bit_nxt   = bit_cnt;
        gap_nxt   = gap_cnt;
        par_nxt   = par_bit;
        tx_nxt    = tx_q;
        tick      = (baud_cnt == 8'd0);
        done      = 1'b0;
        load      = 1'b0;

        if (state == ST_IDLE) begin
            tx_nxt = 1'b1;
            load   = start;
        end else if (tick) begin
            baud_nxt = baud_div;
            case (state)
                ST_START: begin
                    state_nxt = ST_DATA;
                    tx_nxt    = shift[0];
                    shift_nxt = {1'b0, shift[7:1]};
                    bit_nxt   = 3'd0;
                end
                ST_DATA: begin
                    if (bit_cnt == 3'd7) begin
                        state_nxt = par_en ? ST_PARITY : ST_STOP;
                        tx_nxt    = par_en ? par_bit : 1'b1;
                    end else begin
                        bit_nxt   = bit_cnt + 3'd1;
                        tx_nxt    = shift[0];
                        shift_nxt = {1'b0, shift[7:1]};
                    end
                end
                ST_PARITY: begin
                    state_nxt = ST_STOP;
                    tx_nxt    = 1'b1;
                end
                ST_STOP: begin
                    if (GAP_BITS > 0) begin
                        state_nxt = ST_GAP;
                        gap_nxt   = GAP_LOAD;
                        tx_nxt    = 1'b1;
                    end else begin
                        done = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        done = 1'b1;
                    end else begin
                        gap_nxt = gap_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
            if (done) begin
                if (start) begin
                    load = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                    tx_nxt    = 1'b1;
                end
            end
        end else begin
            baud_nxt = baud_cnt - 8'd1;
        end

        // Parity is fixed at load time so it costs nothing during the data bits.
        if (load) begin
            state_nxt = ST_START;
            tx_nxt    = 1'b0;
            shift_nxt = data;
            par_nxt   = (^data) ^ par_typ;
            baud_nxt  = baud_div;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/uart_cmd_framer.sv
// Command framer top: accepts a command, latches its fields and feeds the
// byte serializer one byte after another, pulsing FRAME_DONE when the last
// bit of the last byte has been sent.
module uart_cmd_framer
    import uart_cmd_pkg::*;
#(
    parameter int GAP_BITS = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_VLD,
    input  logic [1:0] CMD_TYPE,
    input  logic [3:0] CMD_ADDR,
    input  logic [7:0] CMD_A,
    input  logic [7:0] CMD_B,
    input  logic [3:0] CMD_FUNC,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [7:0] BAUD_DIV,
    output logic       CMD_RDY,
    output logic       TX_OUT,
    output logic       BUSY,
    output logic       FRAME_DONE
);

    cmd_cfg_t   cfg_in, cfg_q;
    logic       active;
    logic [1:0] byte_idx;
    logic       done_q;
    logic       accept;
    logic       more;
    logic       ser_start;
    logic       ser_done;
    logic       ser_tx;
    logic [7:0] ser_data;
    logic       ser_par_en;
    logic       ser_par_typ;
    logic [7:0] ser_baud;

    assign cfg_in = '{typ: CMD_TYPE, addr: CMD_ADDR, a: CMD_A, b: CMD_B, func: CMD_FUNC,
                      par_en: PAR_EN, par_typ: PAR_TYP, baud_div: BAUD_DIV};

    // On the accept cycle the serializer must see the live inputs, afterwards
    // only the latched copy so mid-frame input changes have no effect.
    always_comb begin
        accept      = CMD_VLD && !active;
        more        = (byte_idx != cmd_last_idx(cfg_q.typ));
        ser_start   = accept || (ser_done && more);
        ser_data    = accept ? cmd_byte(cfg_in, 2'd0) : cmd_byte(cfg_q, byte_idx + 2'd1);
        ser_par_en  = accept ? PAR_EN   : cfg_q.par_en;
        ser_par_typ = accept ? PAR_TYP  : cfg_q.par_typ;
        ser_baud    = accept ? BAUD_DIV : cfg_q.baud_div;
    end

    // Command handshake, field latch and byte sequencing.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            active   <= 1'b0;
            byte_idx <= 2'd0;
            cfg_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                active   <= 1'b1;
                byte_idx <= 2'd0;
                cfg_q    <= cfg_in;
            end else if (ser_done) begin
                if (more) begin
                    byte_idx <= byte_idx + 2'd1;
                end else begin
                    active <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    uart_byte_ser #(.GAP_BITS(GAP_BITS)) u_ser (
        .CLK      (CLK),
        .RST      (RST),
        .start    (ser_start),
        .data     (ser_data),
        .par_en   (ser_par_en),
        .par_typ  (ser_par_typ),
        .baud_div (ser_baud),
        .tx       (ser_tx),
        .done     (ser_done)
    );

    assign CMD_RDY    = !active;
    assign BUSY       = active;
    assign FRAME_DONE = done_q;
    assign TX_OUT     = ser_tx;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Self-checking bench for uart_cmd_framer: the expected line waveform is
// built cycle by cycle from the byte list, framing and timing rules.
module tb_uart_cmd_framer;

    localparam int GAP = 1;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CMD_VLD;
    logic [1:0] CMD_TYPE;
    logic [3:0] CMD_ADDR;
    logic [7:0] CMD_A;
    logic [7:0] CMD_B;
    logic [3:0] CMD_FUNC;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] BAUD_DIV;
    logic       CMD_RDY;
    logic       TX_OUT;
    logic       BUSY;
    logic       FRAME_DONE;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    uart_cmd_framer #(.GAP_BITS(GAP)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CMD_VLD    (CMD_VLD),
        .CMD_TYPE   (CMD_TYPE),
        .CMD_ADDR   (CMD_ADDR),
        .CMD_A      (CMD_A),
        .CMD_B      (CMD_B),
        .CMD_FUNC   (CMD_FUNC),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .BAUD_DIV   (BAUD_DIV),
        .CMD_RDY    (CMD_RDY),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Random junk on every command input except CMD_VLD.
    task automatic scramble();
        CMD_TYPE = 2'($urandom_range(0, 3));
        CMD_ADDR = 4'($urandom_range(0, 15));
        CMD_A    = 8'($urandom_range(0, 255));
        CMD_B    = 8'($urandom_range(0, 255));
        CMD_FUNC = 4'($urandom_range(0, 15));
        PAR_EN   = 1'($urandom_range(0, 1));
        PAR_TYP  = 1'($urandom_range(0, 1));
        BAUD_DIV = 8'($urandom_range(0, 255));
    endtask

    // Present one command, then check every line cycle until FRAME_DONE.
    // hold_vld keeps CMD_VLD high (with changing fields) through the frame;
    // abort_at >= 0 returns early at that cycle index.
    task automatic run_cmd(input logic [1:0] typ, input logic [3:0] addr, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] func, input logic pe,
                           input logic pt, input logic [7:0] bd, input bit hold_vld,
                           input int abort_at);
        logic [7:0] bytes[$];
        logic       wave[$];
        logic [7:0] cur;
        int         w;

        case (typ)
            2'b00: begin bytes.push_back(8'hAA); bytes.push_back({4'h0, addr}); bytes.push_back(a); end
            2'b01: begin bytes.push_back(8'hBB); bytes.push_back({4'h0, addr}); end
            2'b10: begin bytes.push_back(8'hCC); bytes.push_back(a); bytes.push_back(b);
                         bytes.push_back({4'h0, func}); end
            default: begin bytes.push_back(8'hDD); bytes.push_back({4'h0, func}); end
        endcase

        foreach (bytes[n]) begin
            logic lv[$];
            cur = bytes[n];
            lv.push_back(1'b0);
            for (int k = 0; k < 8; k++) lv.push_back(cur[k]);
            if (pe) lv.push_back(pt ? ~(^cur) : (^cur));
            lv.push_back(1'b1);
            for (int g = 0; g < GAP; g++) lv.push_back(1'b1);
            foreach (lv[j])
                for (int r = 0; r <= int'(bd); r++) wave.push_back(lv[j]);
        end

        w = 0;
        while (CMD_RDY !== 1'b1 && w < 2000) begin
            step();
            w++;
        end
        check("ready_before_cmd", CMD_RDY, 1);

        CMD_VLD  = 1'b1;
        CMD_TYPE = typ;
        CMD_ADDR = addr;
        CMD_A    = a;
        CMD_B    = b;
        CMD_FUNC = func;
        PAR_EN   = pe;
        PAR_TYP  = pt;
        BAUD_DIV = bd;
        step();
        if (!hold_vld) CMD_VLD = 1'b0;

        for (int i = 0; i < wave.size(); i++) begin
            if (i == abort_at) return;
            check("tx_line", TX_OUT, wave[i]);
            check("busy_in_frame", BUSY, 1);
            check("rdy_in_frame", CMD_RDY, 0);
            check("done_in_frame", FRAME_DONE, 0);
            scramble();
            step();
        end
        check("frame_done", FRAME_DONE, 1);
        check("rdy_at_done", CMD_RDY, 1);
        check("busy_at_done", BUSY, 0);
        check("line_idle_at_done", TX_OUT, 1);
    endtask

    initial begin
        RST      = 1'b0;
        CMD_VLD  = 1'b0;
        CMD_TYPE = 2'b00;
        CMD_ADDR = 4'h0;
        CMD_A    = 8'h00;
        CMD_B    = 8'h00;
        CMD_FUNC = 4'h0;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        BAUD_DIV = 8'h00;
        repeat (3) step();
        check("rst_tx", TX_OUT, 1);
        check("rst_rdy", CMD_RDY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_done", FRAME_DONE, 0);
        RST = 1'b1;
        step();

        // Register write, no parity, 1-cycle bits: 33 cycles to FRAME_DONE.
        run_cmd(2'b00, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0, -1);
        step();
        check("idle_line_after", TX_OUT, 1);
        check("idle_done_cleared", FRAME_DONE, 0);

        // ALU with operands, even parity, 4-cycle bits: 192 cycles.
        run_cmd(2'b10, 4'h0, 8'h12, 8'h34, 4'h2, 1'b1, 1'b0, 8'd3, 1'b0, -1);

        // Register read, odd parity.
        run_cmd(2'b01, 4'hF, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 8'd1, 1'b0, -1);

        // CMD_VLD held through a type-11 frame; next command taken in the done cycle.
        run_cmd(2'b11, 4'h0, 8'h00, 8'h00, 4'hA, 1'b1, 1'b0, 8'd1, 1'b1, -1);
        run_cmd(2'b10, 4'h3, 8'h81, 8'h7E, 4'h5, 1'b0, 1'b1, 8'd2, 1'b0, -1);

        // Reset during data bits of byte 1, then a clean command.
        run_cmd(2'b00, 4'h9, 8'h5A, 8'h00, 4'h0, 1'b0, 1'b0, 8'd2, 1'b0, 42);
        RST = 1'b0;
        step();
        check("abort_tx", TX_OUT, 1);
        check("abort_rdy", CMD_RDY, 1);
        check("abort_busy", BUSY, 0);
        check("abort_done", FRAME_DONE, 0);
        step();
        check("abort_done_hold", FRAME_DONE, 0);
        RST = 1'b1;
        step();
        check("post_abort_done", FRAME_DONE, 0);
        check("post_abort_tx", TX_OUT, 1);
        run_cmd(2'b01, 4'h6, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'd0, 1'b0, -1);

        // Random commands, occasionally chained through a held CMD_VLD.
        for (int k = 0; k < 10; k++) begin
            run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)),
                    (k < 9) ? 1'($urandom_range(0, 1)) : 1'b0, -1);
        end
        CMD_VLD = 1'b0;
        step();
        check("final_idle_tx", TX_OUT, 1);
        check("final_idle_rdy", CMD_RDY, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
